adc_capture_ctrl: RTL and testbench



---
 rtl/adc_cap_pkg.sv | 14 +
 rtl/adc_capture_ctrl_trigger.sv | 46 ++++
 rtl/adc_capture_ctrl.sv | 130 +++++++++++++
 tb/tb_adc_capture_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture path: sample width and sequencer states.
package adc_cap_pkg;

  // Sample width shared with the ADC interface and FFT blocks.
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/adc_capture_ctrl_trigger.sv
// Trigger front end: two-stage sample pipeline, rising level-crossing detect and
// ARM-state timeout counter; trig_fire is a combinational pulse qualified by arm.
module cap_trigger #(
  parameter int DATA_W  = 12,
  parameter int TRIG_TO = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              arm,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_level,
  output logic [DATA_W-1:0] s0,
  output logic              trig_fire,
  output logic              trig_to
);

  localparam int CW = $clog2(TRIG_TO);

  logic [DATA_W-1:0] s1;
  logic [CW-1:0]     to_cnt;
  logic              crossing;
  logic              to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0     <= '0;
      s1     <= '0;
      to_cnt <= '0;
    end else begin
      s0 <= adc_data;
      s1 <= s0;
      // Counter only runs while armed; any other state leaves it at zero.
      if (!arm)
        to_cnt <= '0;
      else if (!trig_fire)
        to_cnt <= to_cnt + CW'(1);
    end
  end

  assign crossing  = (s1 < trig_level) && (s0 >= trig_level);
  assign to_hit    = (to_cnt == CW'(TRIG_TO - 1));
  assign trig_fire = arm && (!trig_en || crossing || to_hit);
  assign trig_to   = arm && trig_en && !crossing && to_hit;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture sequencer: arms on start, waits for trigger/timeout, writes a decimated
// block of 2^ADDR_W samples to the sample RAM and holds done until acknowledged.
module adc_capture_ctrl #(
  parameter int DATA_W  = adc_cap_pkg::DATA_W,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8,
  parameter int TRIG_TO = 65536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               done_ack,
  input  logic               trig_en,
  input  logic [DATA_W-1:0]  trig_level,
  input  logic [DECIM_W-1:0] decim,
  input  logic [DATA_W-1:0]  adc_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               trig_timeout
);

  import adc_cap_pkg::*;

  cap_state_t         state;
  logic [DATA_W-1:0]  lvl_q;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] dcnt;
  logic [DATA_W-1:0]  s0;
  logic               arm;
  logic               trig_fire;
  logic               trig_to;
  logic               last_wr;

  assign arm     = (state == ARM);
  assign last_wr = wr_en && (wr_addr == {ADDR_W{1'b1}});

  cap_trigger #(
    .DATA_W  (DATA_W),
    .TRIG_TO (TRIG_TO)
  ) u_trig (
    .clk        (clk),
    .rst_n      (rst_n),
    .adc_data   (adc_data),
    .arm        (arm),
    .trig_en    (trig_en),
    .trig_level (lvl_q),
    .s0         (s0),
    .trig_fire  (trig_fire),
    .trig_to    (trig_to)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      trig_timeout <= 1'b0;
      lvl_q        <= '0;
      decim_q      <= '0;
      dcnt         <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= ARM;
            busy         <= 1'b1;
            trig_timeout <= 1'b0;
            lvl_q        <= trig_level;
            decim_q      <= decim;
          end
        end
        ARM: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (trig_fire) begin
            state   <= CAPTURE;
            wr_en   <= 1'b1;
            wr_addr <= '0;
            wr_data <= s0;
            dcnt    <= decim_q;
            if (trig_to)
              trig_timeout <= 1'b1;
          end
        end
        CAPTURE: begin
          // abort outranks the final write, which outranks the next write
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (last_wr) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (dcnt == '0) begin
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + ADDR_W'(1);
            wr_data <= s0;
            dcnt    <= decim_q;
          end else begin
            dcnt <= dcnt - DECIM_W'(1);
          end
        end
        DONE: begin
          if (start) begin
            state        <= ARM;
            done         <= 1'b0;
            busy         <= 1'b1;
            trig_timeout <= 1'b0;
            lvl_q        <= trig_level;
            decim_q      <= decim;
          end else if (done_ack) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl with DEPTH=16 and TRIG_TO=8.
module tb_adc_capture_ctrl;

  localparam int DATA_W  = 12;
  localparam int ADDR_W  = 4;
  localparam int DECIM_W = 8;
  localparam int TRIG_TO = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic               done_ack = 1'b0;
  logic               trig_en = 1'b0;
  logic [DATA_W-1:0]  trig_level = '0;
  logic [DECIM_W-1:0] decim = '0;
  logic [DATA_W-1:0]  adc_data = '0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               busy;
  logic               done;
  logic               trig_timeout;

  int checks = 0;
  int errors = 0;
  bit ramp = 1'b0;
  int nwr;

  always #5 clk = ~clk;

  adc_capture_ctrl #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DECIM_W (DECIM_W),
    .TRIG_TO (TRIG_TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .done_ack     (done_ack),
    .trig_en      (trig_en),
    .trig_level   (trig_level),
    .decim        (decim),
    .adc_data     (adc_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .trig_timeout (trig_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ramp) adc_data = adc_data + DATA_W'(1);
  endtask

  // Steps until done, checking each write address in order from first_addr.
  task automatic run_to_done(input string tag, input int first_addr, output int n);
    int exp_a;
    exp_a = first_addr;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (done) break;
      if (wr_en) begin
        chk({tag, " addr"}, 32'(wr_addr), 32'(exp_a));
        exp_a++;
        n++;
      end
    end
    chk({tag, " done"}, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst wr_addr", 32'(wr_addr), 32'd0);
    chk("rst wr_data", 32'(wr_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst trig_timeout", 32'(trig_timeout), 32'd0);
    rst_n = 1'b1;
    step();

    // Free-run, decim=0, ramp from 100
    trig_en = 1'b0; decim = '0; adc_data = 12'd100; ramp = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fr arm busy", 32'(busy), 32'd1);
    chk("fr arm wr_en", 32'(wr_en), 32'd0);
    step();
    chk("fr w0 wr_en", 32'(wr_en), 32'd1);
    chk("fr w0 addr", 32'(wr_addr), 32'd0);
    chk("fr w0 data", 32'(wr_data), 32'd100);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("fr wr_en", 32'(wr_en), 32'd1);
      chk("fr addr", 32'(wr_addr), 32'(i));
      chk("fr data", 32'(wr_data), 32'(100 + i));
    end
    step();
    chk("fr done", 32'(done), 32'd1);
    chk("fr busy", 32'(busy), 32'd0);
    chk("fr wr_en off", 32'(wr_en), 32'd0);
    chk("fr addr hold", 32'(wr_addr), 32'd15);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("abort in done ignored", 32'(done), 32'd1);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;
    chk("ack done", 32'(done), 32'd0);
    chk("ack busy", 32'(busy), 32'd0);

    // Level trigger at 0x800; trig_level changed after arming must be ignored
    ramp = 1'b0; trig_en = 1'b1; trig_level = 12'h800; adc_data = 12'h7F0;
    start = 1'b1;
    step();
    start = 1'b0; trig_level = 12'hFFF;
    step();
    chk("lvl arm busy", 32'(busy), 32'd1);
    chk("lvl arm wr_en", 32'(wr_en), 32'd0);
    adc_data = 12'h810;
    step();
    chk("lvl cross cycle wr_en", 32'(wr_en), 32'd0);
    step();
    chk("lvl w0 wr_en", 32'(wr_en), 32'd1);
    chk("lvl w0 addr", 32'(wr_addr), 32'd0);
    chk("lvl w0 data", 32'(wr_data), 32'h810);
    run_to_done("lvl", 1, nwr);
    chk("lvl writes", 32'(nwr), 32'd15);
    chk("lvl trig_timeout", 32'(trig_timeout), 32'd0);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;

    // Decimation by 4; decim changed after arming must be ignored
    trig_en = 1'b0; decim = 8'd3; adc_data = '0; ramp = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0; decim = '0;
    step();
    chk("dec w0 wr_en", 32'(wr_en), 32'd1);
    chk("dec w0 data", 32'(wr_data), 32'd0);
    for (int i = 1; i < 16; i++) begin
      repeat (3) begin
        step();
        chk("dec gap wr_en", 32'(wr_en), 32'd0);
      end
      chk("dec hold addr", 32'(wr_addr), 32'(i - 1));
      step();
      chk("dec wr_en", 32'(wr_en), 32'd1);
      chk("dec addr", 32'(wr_addr), 32'(i));
      chk("dec data", 32'(wr_data), 32'(4 * i));
    end
    step();
    chk("dec done", 32'(done), 32'd1);
    done_ack = 1'b1;
    step();
    done_ack = 1'b0;

    // Timeout: constant input below level, forced trigger after 8 ARM cycles
    ramp = 1'b0; decim = '0; trig_en = 1'b1; trig_level = 12'h800; adc_data = 12'h100;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("to arm wr_en", 32'(wr_en), 32'd0);
    end
    chk("to arm busy", 32'(busy), 32'd1);
    chk("to arm flag", 32'(trig_timeout), 32'd0);
    step();
    chk("to w0 wr_en", 32'(wr_en), 32'd1);
    chk("to w0 data", 32'(wr_data), 32'h100);
    chk("to flag set", 32'(trig_timeout), 32'd1);
    run_to_done("to", 1, nwr);
    chk("to writes", 32'(nwr), 32'd15);
    chk("to flag sticky", 32'(trig_timeout), 32'd1);

    // start + done_ack together in DONE re-arms; start mid-capture ignored; abort at 5th write
    start = 1'b1; done_ack = 1'b1; trig_en = 1'b0; adc_data = '0; ramp = 1'b1;
    step();
    start = 1'b0; done_ack = 1'b0;
    chk("hs done cleared", 32'(done), 32'd0);
    chk("hs busy", 32'(busy), 32'd1);
    chk("hs flag cleared", 32'(trig_timeout), 32'd0);
    step();
    chk("hs w0 addr", 32'(wr_addr), 32'd0);
    chk("hs w0 wr_en", 32'(wr_en), 32'd1);
    for (int i = 1; i < 5; i++) begin
      start = (i == 2);
      step();
      chk("hs addr", 32'(wr_addr), 32'(i));
      chk("hs data", 32'(wr_data), 32'(i));
    end
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab wr_en", 32'(wr_en), 32'd0);
    chk("ab busy", 32'(busy), 32'd0);
    chk("ab done", 32'(done), 32'd0);
    repeat (3) step();
    chk("ab quiet wr_en", 32'(wr_en), 32'd0);
    chk("ab quiet done", 32'(done), 32'd0);

    // Full capture after abort restarts at address 0
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("re w0 wr_en", 32'(wr_en), 32'd1);
    chk("re w0 addr", 32'(wr_addr), 32'd0);
    run_to_done("re", 1, nwr);
    chk("re writes", 32'(nwr), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
